control_seq: RTL and testbench

CONTROL_SEQ -- requirements
Module: control_seq

---
 rtl/control_seq.sv | 158 +++++++++++++++
 tb/tb_control_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_seq.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP state.
// Optional MISALIGN_TRAP_EN: misaligned taken branch/JAL targets trap instead of being truncated.
module control_seq #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] ir,
   input  logic [4:0]  opcode,
   input  logic        invalid,
   input  logic [31:0] data_addr,
   input  logic [31:0] target,
   input  logic        branch_taken,
   output logic [31:0] pc,
   output logic        rf_we,
   output logic        retire,
   output logic        trap,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StExec   = 3'd2,
      StMem    = 3'd3,
      StWb     = 3'd4,
      StTrap   = 3'd5
   } state_e;

   localparam logic [4:0] OpLoad   = 5'b00000;
   localparam logic [4:0] OpStore  = 5'b01000;
   localparam logic [4:0] OpBranch = 5'b11000;
   localparam logic [4:0] OpJal    = 5'b11011;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;

   logic        is_load, is_store, is_branch, is_jal;
   logic [31:0] pc_inc;
   logic [31:0] tgt_pc;
   logic        tgt_bad;

   assign is_load   = (opcode == OpLoad);
   assign is_store  = (opcode == OpStore);
   assign is_branch = (opcode == OpBranch);
   assign is_jal    = (opcode == OpJal);
   assign pc_inc    = pc_q + 32'd4;

`ifdef MISALIGN_TRAP_EN
   assign tgt_pc  = target;
   assign tgt_bad = |target[1:0];
`else
   assign tgt_pc  = target & 32'hFFFF_FFFC;
   assign tgt_bad = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StFetch;
         pc_q    <= RESET_PC;
         ir_q    <= 32'h0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      case (state_q)
         StFetch: begin
            if (mem_ack) begin
               ir_d    = mem_rdata;
               state_d = StDecode;
            end
         end
         StDecode: state_d = invalid ? StTrap : StExec;
         StExec: begin
            if (is_load || is_store) begin
               state_d = StMem;
            end else if (is_branch) begin
               if (branch_taken && tgt_bad) begin
                  state_d = StTrap;
               end else begin
                  pc_d    = branch_taken ? tgt_pc : pc_inc;
                  state_d = StFetch;
               end
            end else begin
               state_d = StWb;
            end
         end
         StMem: begin
            if (mem_ack) begin
               if (is_store) begin
                  pc_d    = pc_inc;
                  state_d = StFetch;
               end else begin
                  state_d = StWb;
               end
            end
         end
         StWb: begin
            if (is_jal && tgt_bad) begin
               state_d = StTrap;
            end else begin
               pc_d    = is_jal ? tgt_pc : pc_inc;
               state_d = StFetch;
            end
         end
         StTrap:  state_d = StTrap;
         default: state_d = StTrap;
      endcase
   end

   always_comb begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      mem_addr = pc_q;
      rf_we    = 1'b0;
      retire   = 1'b0;
      case (state_q)
         StFetch: mem_req = 1'b1;
         StExec:  retire  = is_branch && !(branch_taken && tgt_bad);
         StMem: begin
            mem_req  = 1'b1;
            mem_we   = is_store;
            mem_addr = data_addr;
            retire   = mem_ack && is_store;
         end
         StWb: begin
            rf_we  = !(is_jal && tgt_bad);
            retire = !(is_jal && tgt_bad);
         end
         default: ;
      endcase
      // Reset must silence the bus and strobes immediately, not at the next edge.
      if (!rst_n) begin
         mem_req = 1'b0;
         rf_we   = 1'b0;
         retire  = 1'b0;
      end
   end

   assign pc    = pc_q;
   assign ir    = ir_q;
   assign trap  = (state_q == StTrap);
   assign state = state_q;

endmodule

// File: tb/tb_control_seq.sv
// Self-checking bench for control_seq: per-instruction cycle model plus literal pins.
module tb_control_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_rdata, ir, data_addr, target, pc;
   logic [4:0]  opcode;
   logic        invalid, branch_taken, rf_we, retire, trap;
   logic [2:0]  state;

   localparam logic [31:0] ResetPc = 32'h0000_0000;

   control_seq #(.RESET_PC(ResetPc)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .ir           (ir),
      .opcode       (opcode),
      .invalid      (invalid),
      .data_addr    (data_addr),
      .target       (target),
      .branch_taken (branch_taken),
      .pc           (pc),
      .rf_we        (rf_we),
      .retire       (retire),
      .trap         (trap),
      .state        (state)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int n_cyc = 0;

   // Architectural model state
   logic [31:0] m_pc, m_ir;
   logic        m_trapped;
   logic        cur_tk;
   logic [31:0] cur_tgt, cur_da;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic misaligned(input logic [31:0] t);
`ifdef MISALIGN_TRAP_EN
      return |t[1:0];
`else
      return (t == 32'hFFFF_FFFF) && 1'b0;
`endif
   endfunction

   function automatic logic [31:0] aligned(input logic [31:0] t);
`ifdef MISALIGN_TRAP_EN
      return t;
`else
      return {t[31:2], 2'b00};
`endif
   endfunction

   // One clock: drive at negedge, compare 1ns later, then the posedge commits.
   task automatic cyc(input logic ack, input logic [31:0] rdata, input logic inv,
                      input logic [2:0] e_st, input logic e_req, input logic e_we,
                      input logic [31:0] e_addr, input logic e_rf, input logic e_ret);
      @(negedge clk);
      mem_ack      = ack;
      mem_rdata    = rdata;
      invalid      = inv;
      opcode       = m_ir[6:2];
      branch_taken = cur_tk;
      target       = cur_tgt;
      data_addr    = cur_da;
      #1;
      n_cyc++;
      check("state", {29'd0, state}, {29'd0, e_st});
      check("mem_req", {31'd0, mem_req}, {31'd0, e_req});
      if (e_req) begin
         check("mem_we", {31'd0, mem_we}, {31'd0, e_we});
         check("mem_addr", mem_addr, e_addr);
      end
      check("pc", pc, m_pc);
      check("ir", ir, m_ir);
      check("rf_we", {31'd0, rf_we}, {31'd0, e_rf});
      check("retire", {31'd0, retire}, {31'd0, e_ret});
      check("trap", {31'd0, trap}, {31'd0, (e_st == 3'd5)});
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      mem_ack = 1'b1;
      #1;
      check("rst_state", {29'd0, state}, 32'd0);
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_rf_we", {31'd0, rf_we}, 32'd0);
      check("rst_retire", {31'd0, retire}, 32'd0);
      check("rst_trap", {31'd0, trap}, 32'd0);
      check("rst_pc", pc, ResetPc);
      check("rst_ir", ir, 32'h0);
      repeat (2) @(posedge clk);
      #2;
      rst_n     = 1'b1;
      m_pc      = ResetPc;
      m_ir      = 32'h0;
      m_trapped = 1'b0;
   endtask

   task automatic run_instr(input logic [31:0] word, input logic inv, input int fwait,
                            input int mwait, input logic tk, input logic [31:0] tgt,
                            input logic [31:0] da, input logic abort);
      logic [4:0] op;
      logic       mis;
      cur_tk  = tk;
      cur_tgt = tgt;
      cur_da  = da;
      for (int i = 0; i <= fwait; i++)
         cyc(i == fwait, (i == fwait) ? word : 32'hBAD0_0000 + i, 1'b0, 3'd0, 1'b1, 1'b0,
             m_pc, 1'b0, 1'b0);
      m_ir = word;
      op   = word[6:2];
      cyc(1'b0, 32'h0, inv, 3'd1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      if (inv) begin
         m_trapped = 1'b1;
         return;
      end
      if (op == 5'b00000 || op == 5'b01000) begin
         cyc(1'b0, 32'h0, 1'b0, 3'd2, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
         for (int i = 0; i <= mwait; i++) begin
            cyc(i == mwait, 32'h1234_0000 + i, 1'b0, 3'd3, 1'b1, op == 5'b01000, da, 1'b0,
                (i == mwait) && (op == 5'b01000));
            if (abort) begin
               do_reset();
               return;
            end
         end
         if (op == 5'b00000) cyc(1'b0, 32'h0, 1'b0, 3'd4, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
         m_pc = m_pc + 32'd4;
      end else if (op == 5'b11000) begin
         mis = tk && misaligned(tgt);
         cyc(1'b0, 32'h0, 1'b0, 3'd2, 1'b0, 1'b0, 32'h0, 1'b0, !mis);
         if (mis) m_trapped = 1'b1;
         else m_pc = tk ? aligned(tgt) : m_pc + 32'd4;
      end else begin
         cyc(1'b0, 32'h0, 1'b0, 3'd2, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
         mis = (op == 5'b11011) && misaligned(tgt);
         cyc(1'b0, 32'h0, 1'b0, 3'd4, 1'b0, 1'b0, 32'h0, !mis, !mis);
         if (mis) m_trapped = 1'b1;
         else m_pc = (op == 5'b11011) ? aligned(tgt) : m_pc + 32'd4;
      end
   endtask

   // Trap must ignore memory acks entirely.
   task automatic run_trap(input int n);
      for (int i = 0; i < n; i++)
         cyc(i[0], $urandom, 1'b0, 3'd5, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic pin_pc(input string name, input logic [31:0] exp);
      @(posedge clk);
      #1;
      check(name, pc, exp);
   endtask

   localparam logic [31:0] Addi = 32'h0050_0093;
   localparam logic [31:0] Beq  = 32'h0000_0063;
   localparam logic [31:0] Sw   = 32'h0011_2023;
   localparam logic [31:0] Lw   = 32'h0000_2083;
   localparam logic [31:0] Jal  = 32'h0000_006F;
   localparam logic [31:0] Bad  = 32'hFFFF_FFFF;

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int c0;
      rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0; opcode = 5'd0; invalid = 1'b0;
      data_addr = 32'h0; target = 32'h0; branch_taken = 1'b0;
      cur_tk = 1'b0; cur_tgt = 32'h0; cur_da = 32'h0;
      m_pc = ResetPc; m_ir = 32'h0; m_trapped = 1'b0;
      do_reset();

      c0 = n_cyc;
      run_instr(Addi, 1'b0, 2, 0, 1'b0, 32'h0, 32'h0, 1'b0);
      check("addi_cycles", n_cyc - c0, 32'd6);
      pin_pc("addi_pc", 32'h4);

      c0 = n_cyc;
      run_instr(Addi, 1'b0, 0, 0, 1'b0, 32'h0, 32'h0, 1'b0);
      check("alu_latency", n_cyc - c0, 32'd4);
      pin_pc("addi2_pc", 32'h8);

      c0 = n_cyc;
      run_instr(Beq, 1'b0, 0, 0, 1'b1, 32'h100, 32'h0, 1'b0);
      check("branch_latency", n_cyc - c0, 32'd3);
      pin_pc("branch_pc", 32'h100);

      c0 = n_cyc;
      run_instr(Sw, 1'b0, 0, 2, 1'b0, 32'h0, 32'h80, 1'b0);
      check("store_cycles", n_cyc - c0, 32'd6);
      pin_pc("store_pc", 32'h104);

      c0 = n_cyc;
      run_instr(Lw, 1'b0, 0, 0, 1'b0, 32'h0, 32'h84, 1'b0);
      check("load_latency", n_cyc - c0, 32'd5);
      pin_pc("load_pc", 32'h108);

      run_instr(Beq, 1'b0, 1, 0, 1'b0, 32'h200, 32'h0, 1'b0);
      pin_pc("bnt_pc", 32'h10C);

      run_instr(Jal, 1'b0, 0, 0, 1'b0, 32'h102, 32'h0, 1'b0);
`ifdef MISALIGN_TRAP_EN
      run_trap(3);
      check("jal_mis_trap", {31'd0, trap}, 32'd1);
      do_reset();
`else
      pin_pc("jal_pc", 32'h100);
`endif

      run_instr(Beq, 1'b0, 0, 0, 1'b1, 32'hFFFF_FFFC, 32'h0, 1'b0);
      run_instr(Addi, 1'b0, 0, 0, 1'b0, 32'h0, 32'h0, 1'b0);
      pin_pc("pc_wrap", 32'h0);

      run_instr(Addi, 1'b0, 0, 0, 1'b0, 32'h0, 32'h0, 1'b0);
      run_instr(Lw, 1'b0, 0, 3, 1'b0, 32'h0, 32'h40, 1'b1);
      run_instr(Addi, 1'b0, 0, 0, 1'b0, 32'h0, 32'h0, 1'b0);
      pin_pc("after_abort_pc", ResetPc + 32'h4);

      run_instr(Bad, 1'b1, 0, 0, 1'b0, 32'h0, 32'h0, 1'b0);
      run_trap(20);
      do_reset();
      run_instr(Addi, 1'b0, 0, 0, 1'b0, 32'h0, 32'h0, 1'b0);
      pin_pc("post_trap_pc", 32'h4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
